// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, segment table and state type for seg7_scan_mux
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_W = SEG_G - SEG_A + 1;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost listed value.
  localparam logic [15:0][SEG_W-1:0] SEG_HEX_N = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    ST_BLANK,
    ST_SCAN
  } state_e;

endpackage

// File: rtl/seg7_scan_mux_if.sv
// rtl/seg7_scan_mux_if.sv - value handshake between status logic and seg7_scan_mux
interface seg7_scan_mux_if #(
  parameter int DIGITS = 4
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_data;
  logic [DIGITS-1:0]     in_dp;

  modport master (output in_valid, output in_data, output in_dp, input in_ready);
  modport slave  (input in_valid, input in_data, input in_dp, output in_ready);

endinterface

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - 4-bit hex to active-low 7-segment pattern
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg_n
);

  assign seg_n = SEG_HEX_N[nibble];

endmodule

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - time-multiplexed multi-digit 7-segment driver
// Values are double-buffered and only swapped in at frame boundaries.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int PRESCALE      = 50000,
  parameter int GUARD         = 500,
  parameter int LEADING_BLANK = 1
) (
  input  logic              clk,
  input  logic              rstn,
  seg7_scan_mux_if.slave    in_if,
  output logic [6:0]        segments_n,
  output logic              dp_n,
  output logic [DIGITS-1:0] digit_en_n
);

  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]          pcnt_q, pcnt_d;
  logic [DW-1:0]          dig_q, dig_d;
  state_e                 state_q, state_d;
  logic                   pend_full_q, pend_full_d;
  logic [4*DIGITS-1:0]    pend_data_q, pend_data_d;
  logic [DIGITS-1:0]      pend_dp_q, pend_dp_d;
  logic [4*DIGITS-1:0]    disp_data_q, disp_data_d;
  logic [DIGITS-1:0]      disp_dp_q, disp_dp_d;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_q, dp_d;
  logic [DIGITS-1:0]      en_q, en_d;

  logic                   last_slot;
  logic                   boundary;
  logic                   take;
  logic                   nz;
  logic [DIGITS-1:0]      lit_mask;
  logic [3:0]             sel_nib;
  logic                   sel_dp;
  logic                   sel_lit;
  logic [6:0]             dec_seg;

  assign in_if.in_ready = !pend_full_q;

  always_comb begin
    last_slot = (pcnt_q == PW'(PRESCALE - 1));
    boundary  = last_slot && (dig_q == DW'(DIGITS - 1));
    take      = in_if.in_valid && !pend_full_q;

    pcnt_d = last_slot ? '0 : pcnt_q + 1'b1;
    dig_d  = dig_q;
    if (last_slot) begin
      dig_d = (dig_q == DW'(DIGITS - 1)) ? '0 : dig_q + 1'b1;
    end

    state_d     = state_q;
    pend_full_d = pend_full_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    disp_data_d = disp_data_q;
    disp_dp_d   = disp_dp_q;
    // take and a consuming boundary are exclusive: take needs pend_full_q low.
    if (boundary && pend_full_q) begin
      disp_data_d = pend_data_q;
      disp_dp_d   = pend_dp_q;
      pend_full_d = 1'b0;
      state_d     = ST_SCAN;
    end else if (take) begin
      pend_data_d = in_if.in_data;
      pend_dp_d   = in_if.in_dp;
      pend_full_d = 1'b1;
    end
  end

  // A digit stays lit if it or any more-significant nibble is non-zero.
  always_comb begin
    nz       = 1'b0;
    lit_mask = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz          = nz | (|disp_data_q[4*i +: 4]);
      lit_mask[i] = nz || (i == 0) || (LEADING_BLANK == 0);
    end
  end

  always_comb begin
    sel_nib = disp_data_q[3:0];
    sel_dp  = disp_dp_q[0];
    sel_lit = lit_mask[0];
    for (int i = 1; i < DIGITS; i++) begin
      if (dig_q == DW'(i)) begin
        sel_nib = disp_data_q[4*i +: 4];
        sel_dp  = disp_dp_q[i];
        sel_lit = lit_mask[i];
      end
    end
  end

  seg7_hex_decode u_dec (
    .nibble (sel_nib),
    .seg_n  (dec_seg)
  );

  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    en_d  = '1;
    if (state_q == ST_SCAN && pcnt_q >= PW'(GUARD) && sel_lit) begin
      seg_d = dec_seg;
      dp_d  = !sel_dp;
      for (int i = 0; i < DIGITS; i++) begin
        if (dig_q == DW'(i)) en_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pcnt_q      <= '0;
      dig_q       <= '0;
      state_q     <= ST_BLANK;
      pend_full_q <= 1'b0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      disp_data_q <= '0;
      disp_dp_q   <= '0;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
      en_q        <= '1;
    end else begin
      pcnt_q      <= pcnt_d;
      dig_q       <= dig_d;
      state_q     <= state_d;
      pend_full_q <= pend_full_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      disp_data_q <= disp_data_d;
      disp_dp_q   <= disp_dp_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      en_q        <= en_d;
    end
  end

  assign segments_n = seg_q;
  assign dp_n       = dp_q;
  assign digit_en_n = en_q;

endmodule
